snoop_bus_arbiter: RTL and testbench
====================================

Name: snoop_bus_arbiter

Overview:
- Owns the shared snooping bus between the four per-core Cache instances and the memory side.
- Arbitrates bus requests from each core's cache miss and write-back logic using round-robin.
- Broadcasts the winning core's ID, address and RdWr to every cache as currProc_ID/address/RdWr, then collects the snoop responses (shared, write-back).
- Sequences the write-back, memory fill and readyToRead handshake for the transaction.

Parameters:
- NUM_PROC, 4, number of cores/caches on the bus
- ID_W, 2, width of processor ID; must be at least clog2(NUM_PROC)
- ADDR_W, 32, bus address width
- MEM_LAT, 3, memory access cycles for both fill and write-back; minimum 1

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-low; clears all state when 0 at a rising clk edge
- req  in  NUM_PROC  per-core bus request (RdMs|WrMs from that cache); level, held until done
- req_rdwr  in  NUM_PROC  per-core op: 1 = read, 0 = write
- req_addr  in  NUM_PROC*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W]
- snoop_shared  in  NUM_PROC  per-cache sharedOut
- snoop_wrbk  in  NUM_PROC  per-cache WrBk
- gnt  out  NUM_PROC  one-hot grant; held for the whole transaction
- bus_proc_id  out  ID_W  current owner ID, drives each cache's currProc_ID
- bus_addr  out  ADDR_W  latched address of the winner
- bus_rdwr  out  1  latched op of the winner
- bus_valid  out  1  one-cycle strobe in the ADDR state
- shared_out  out  1  registered OR of snoop_shared over non-owner cores
- wb_en  out  1  high throughout the WB state
- wb_proc_id  out  ID_W  lowest-index non-owner core asserting snoop_wrbk
- mem_req  out  1  high throughout the MEM state
- ready_to_read  out  1  one-cycle pulse on the last MEM cycle, read transactions only
- done  out  NUM_PROC  one-hot, one-cycle completion pulse to the owner
- busy  out  1  high whenever state is not IDLE

Behaviour:

Reset:
- All outputs reset to 0.
- State goes to IDLE, cycle counter to 0.
- Round-robin pointer goes to NUM_PROC-1, so core 0 has first priority.
- Reset asserted mid-transaction abandons it: no done pulse, no ready_to_read, and grant, address and snoop results are cleared on that edge.

State machine (one state per cycle unless stated):
- IDLE: if req is nonzero, select the first requester searching ptr+1, ptr+2, ... (mod NUM_PROC).
  - Register gnt, bus_proc_id, bus_addr = req_addr[winner] and bus_rdwr = req_rdwr[winner].
  - Next state ADDR. If req is 0, stay in IDLE.
- ADDR: bus_valid = 1. Next state SNOOP.
- SNOOP: sample snoop_shared and snoop_wrbk masked with ~gnt; the owner's own lines are ignored.
  - Register shared_out. It holds until DONE is left.
  - If the masked wrbk is nonzero, register wb_proc_id (lowest index) and go to WB; otherwise go to MEM.
- WB: wb_en = 1 for exactly MEM_LAT cycles. Next state MEM.
- MEM: mem_req = 1 for exactly MEM_LAT cycles.
  - ready_to_read = 1 on the final MEM cycle only, and only if bus_rdwr = 1.
  - Next state DONE.
- DONE: done[winner] = 1 and ptr = winner.
  - Next state IDLE; gnt, bus_valid, wb_en and shared_out return to 0 on entry to IDLE.
  - bus_proc_id/bus_addr/bus_rdwr hold their last value until the next grant.

Latency:
- Grant is visible 1 cycle after req is first seen in IDLE.
- Cycles from grant to done pulse, inclusive: 3 + MEM_LAT without write-back, 3 + 2*MEM_LAT with write-back.

Handshake and boundary rules:
- req and request fields are sampled only in IDLE.
  - Changes while busy are ignored.
  - Deassertion of the owner's req mid-transaction does not abort.
- If the owner still asserts req in the IDLE cycle after DONE, it is a new request; the rotated priority means any other requester wins first.
- Simultaneous requests are resolved by the round-robin order only; no starvation, and each core waits at most NUM_PROC-1 transactions.
- Multiple write-back asserters: only the lowest index is served. Coherence guarantees at most one Modified copy; the bench flags more than one as an error.
- The cycle counter is ID-independent and wraps to 0 on every state exit.
- Outputs are registered; there are no combinational paths from req to gnt.

Test Plan:
1. Single read, no sharing: after reset, req=0100, req_rdwr[2]=1, addr=0x0000_1204, snoops 0.
   - Next cycle gnt=0100, bus_proc_id=2, bus_addr=0x1204; bus_valid the cycle after.
   - shared_out=0; mem_req 3 cycles; ready_to_read on the 3rd; done=0100 six cycles after grant.
2. Full contention: req=1111 held continuously from reset, each core dropping req the cycle after its done.
   - Grants in order 0,1,2,3, then idle.
   - Repeat with req=1111 after core 1 last owned: order is 2,3,0,1.
3. Shared read: core 3 reads with snoop_shared=1010.
   - shared_out=1 from SNOOP until DONE.
   - Repeat with snoop_shared=1000 (owner only): shared_out=0.
4. Write with write-back: core 0 write, snoop_wrbk=0100.
   - wb_en 3 cycles with wb_proc_id=2, then mem_req 3 cycles.
   - ready_to_read stays 0; done=0001 nine cycles after grant.
5. Reset mid-MEM: reset=0 for one edge during the 2nd mem_req cycle.
   - Next cycle all outputs 0, no done pulse.
   - Pending req=0010 is granted core 1 one cycle after reset is released.
6. Mid-transaction noise: while core 1 is busy, toggle req[1]=0 and change req_addr[1].
   - bus_addr is unchanged and the transaction completes normally with done=0010.

Source files
------------

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared snooping bus between the per-core caches and memory.
// Sequences address broadcast, snoop collection, optional write-back, memory access and done.
module snoop_bus_arbiter #(
    parameter int unsigned NUM_PROC = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MEM_LAT  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PROC-1:0]        req,
    input  logic [NUM_PROC-1:0]        req_rdwr,
    input  logic [NUM_PROC*ADDR_W-1:0] req_addr,
    input  logic [NUM_PROC-1:0]        snoop_shared,
    input  logic [NUM_PROC-1:0]        snoop_wrbk,
    output logic [NUM_PROC-1:0]        gnt,
    output logic [ID_W-1:0]            bus_proc_id,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic                       bus_rdwr,
    output logic                       bus_valid,
    output logic                       shared_out,
    output logic                       wb_en,
    output logic [ID_W-1:0]            wb_proc_id,
    output logic                       mem_req,
    output logic                       ready_to_read,
    output logic [NUM_PROC-1:0]        done,
    output logic                       busy
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StSnoop,
        StWb,
        StMem,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [NUM_PROC-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rdwr_q, rdwr_d;
    logic                shared_q, shared_d;
    logic [ID_W-1:0]     wb_id_q, wb_id_d;

    logic [ID_W-1:0]     win_idx, hi_idx, lo_idx;
    logic                hi_found;
    logic [ADDR_W-1:0]   win_addr;
    logic                win_rdwr;
    logic [NUM_PROC-1:0] snoop_wrbk_m;
    logic [NUM_PROC-1:0] snoop_shared_m;
    logic [ID_W-1:0]     wb_low;

    // The owner's own snoop lines never count as a remote response.
    assign snoop_wrbk_m   = snoop_wrbk & ~gnt_q;
    assign snoop_shared_m = snoop_shared & ~gnt_q;

    // Round robin: lowest requester above ptr wins, else wrap to the lowest requester overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM_PROC - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_idx = ID_W'(j);
                if (j > int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(j);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        win_addr = '0;
        win_rdwr = 1'b0;
        for (int j = 0; j < NUM_PROC; j++) begin
            if (win_idx == ID_W'(j)) begin
                win_addr = req_addr[j*ADDR_W +: ADDR_W];
                win_rdwr = req_rdwr[j];
            end
        end
    end

    always_comb begin
        wb_low = '0;
        for (int j = NUM_PROC - 1; j >= 0; j--) begin
            if (snoop_wrbk_m[j]) begin
                wb_low = ID_W'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        addr_d   = addr_q;
        rdwr_d   = rdwr_q;
        shared_d = shared_q;
        wb_id_d  = wb_id_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d   = NUM_PROC'(1) << win_idx;
                    id_d    = win_idx;
                    addr_d  = win_addr;
                    rdwr_d  = win_rdwr;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                state_d = StSnoop;
            end
            StSnoop: begin
                shared_d = |snoop_shared_m;
                if (|snoop_wrbk_m) begin
                    wb_id_d = wb_low;
                    state_d = StWb;
                end else begin
                    state_d = StMem;
                end
            end
            StWb: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StMem;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StMem: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                ptr_d    = id_q;
                gnt_d    = '0;
                shared_d = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= ID_W'(NUM_PROC - 1);
            gnt_q    <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            rdwr_q   <= 1'b0;
            shared_q <= 1'b0;
            wb_id_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            rdwr_q   <= rdwr_d;
            shared_q <= shared_d;
            wb_id_q  <= wb_id_d;
        end
    end

    // Strobes are pure decodes of registered state, so no input reaches an output combinationally.
    assign gnt           = gnt_q;
    assign bus_proc_id   = id_q;
    assign bus_addr      = addr_q;
    assign bus_rdwr      = rdwr_q;
    assign bus_valid     = (state_q == StAddr);
    assign shared_out    = shared_q;
    assign wb_en         = (state_q == StWb);
    assign wb_proc_id    = wb_id_q;
    assign mem_req       = (state_q == StMem);
    assign ready_to_read = (state_q == StMem) && (cnt_q == CntLast) && rdwr_q;
    assign done          = (state_q == StDone) ? gnt_q : '0;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: a transaction vector table plus hand-written
// contention, reset-abort and mid-transaction-noise sequences.
module tb_snoop_bus_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NP-1:0]  req = '0;
    logic [NP-1:0]  req_rdwr = '0;
    logic [NP*AW-1:0] req_addr = '0;
    logic [NP-1:0]  snoop_shared = '0;
    logic [NP-1:0]  snoop_wrbk = '0;
    logic [NP-1:0]  gnt;
    logic [1:0]     bus_proc_id;
    logic [AW-1:0]  bus_addr;
    logic           bus_rdwr;
    logic           bus_valid;
    logic           shared_out;
    logic           wb_en;
    logic [1:0]     wb_proc_id;
    logic           mem_req;
    logic           ready_to_read;
    logic [NP-1:0]  done;
    logic           busy;

    int n_pass = 0;
    int n_total = 0;

    snoop_bus_arbiter #(
        .NUM_PROC (4),
        .ID_W     (2),
        .ADDR_W   (32),
        .MEM_LAT  (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_rdwr      (req_rdwr),
        .req_addr      (req_addr),
        .snoop_shared  (snoop_shared),
        .snoop_wrbk    (snoop_wrbk),
        .gnt           (gnt),
        .bus_proc_id   (bus_proc_id),
        .bus_addr      (bus_addr),
        .bus_rdwr      (bus_rdwr),
        .bus_valid     (bus_valid),
        .shared_out    (shared_out),
        .wb_en         (wb_en),
        .wb_proc_id    (wb_proc_id),
        .mem_req       (mem_req),
        .ready_to_read (ready_to_read),
        .done          (done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  rdwr;
        logic [31:0] base;
        logic [3:0]  sh;
        logic [3:0]  wb;
        int          win;
        logic [31:0] exp_addr;
        logic        exp_sh;
        logic        exp_wb;
        int          exp_wb_id;
        logic        exp_rd;
    } vec_t;

    vec_t tv[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [13:0] ev(input logic [3:0] g, input logic bv, input logic sh,
                                       input logic wb, input logic mr, input logic rr,
                                       input logic [3:0] dn, input logic bz);
        return {g, bv, sh, wb, mr, rr, dn, bz};
    endfunction

    function automatic logic [13:0] outv();
        return {gnt, bus_valid, shared_out, wb_en, mem_req, ready_to_read, done, busy};
    endfunction

    // Called in an IDLE cycle with the request already driven; ends in the following IDLE cycle.
    task automatic run_txn(input string name, input int win, input logic [31:0] exp_addr,
                           input logic exp_sh, input logic exp_wb, input int wb_id,
                           input logic exp_rd, input bit noise);
        logic [3:0] g;
        g = 4'b0001 << win;
        tick();
        chk({name, ".addr_cyc"}, outv(), ev(g, 1, 0, 0, 0, 0, 4'b0, 1));
        chk({name, ".proc_id"}, bus_proc_id, wb_id == -1 ? 64'(win) : 64'(win));
        chk({name, ".bus_addr"}, bus_addr, exp_addr);
        chk({name, ".bus_rdwr"}, bus_rdwr, exp_rd);
        if (noise) begin
            req[win] = 1'b0;
            req_addr[win*AW +: AW] = 32'hDEAD_BEEF;
            req_rdwr[win] = ~req_rdwr[win];
        end
        tick();
        chk({name, ".snoop_cyc"}, outv(), ev(g, 0, 0, 0, 0, 0, 4'b0, 1));
        if (exp_wb) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                chk({name, ".wb_cyc"}, outv(), ev(g, 0, exp_sh, 1, 0, 0, 4'b0, 1));
                if (k == 0) chk({name, ".wb_proc_id"}, wb_proc_id, wb_id);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk({name, ".mem_cyc"}, outv(),
                ev(g, 0, exp_sh, 0, 1, (k == 2) && exp_rd, 4'b0, 1));
        end
        tick();
        chk({name, ".done_cyc"}, outv(), ev(g, 0, exp_sh, 0, 0, 0, g, 1));
        chk({name, ".addr_held"}, bus_addr, exp_addr);
        chk({name, ".rdwr_held"}, bus_rdwr, exp_rd);
        req[win] = 1'b0;
        tick();
        chk({name, ".idle_cyc"}, outv(), ev(4'b0, 0, 0, 0, 0, 0, 4'b0, 0));
        chk({name, ".id_kept"}, bus_proc_id, win);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order_a[4];
        int order_b[4];
        order_a = '{0, 1, 2, 3};
        order_b = '{2, 3, 0, 1};

        // req, rdwr, base, shared, wrbk, win, exp_addr, exp_sh, exp_wb, wb_id, exp_rd
        tv[0] = '{4'b0100, 4'b0100, 32'h0000_1004, 4'b0000, 4'b0000, 2, 32'h0000_1204,
                  1'b0, 1'b0, 0, 1'b1};
        tv[1] = '{4'b1000, 4'b1000, 32'hA000_0000, 4'b1010, 4'b0000, 3, 32'hA000_0300,
                  1'b1, 1'b0, 0, 1'b1};
        tv[2] = '{4'b1000, 4'b1000, 32'hA000_0040, 4'b1000, 4'b0000, 3, 32'hA000_0340,
                  1'b0, 1'b0, 0, 1'b1};
        tv[3] = '{4'b0001, 4'b0000, 32'h0000_BEEF, 4'b0000, 4'b0100, 0, 32'h0000_BEEF,
                  1'b0, 1'b1, 2, 1'b0};
        tv[4] = '{4'b0110, 4'b0110, 32'h4000_0010, 4'b0001, 4'b0000, 1, 32'h4000_0110,
                  1'b1, 1'b0, 0, 1'b1};
        tv[5] = '{4'b0101, 4'b0100, 32'h5555_0000, 4'b0000, 4'b0101, 2, 32'h5555_0200,
                  1'b0, 1'b1, 0, 1'b1};
        tv[6] = '{4'b0011, 4'b0001, 32'hFFFF_FF00, 4'b0000, 4'b0001, 0, 32'hFFFF_FF00,
                  1'b0, 1'b0, 0, 1'b1};
        tv[7] = '{4'b1001, 4'b0000, 32'h1234_5678, 4'b0100, 4'b0010, 3, 32'h1234_5978,
                  1'b1, 1'b1, 1, 1'b0};

        tick();
        tick();
        chk("reset.outputs", outv(), 14'b0);
        chk("reset.bus_addr", bus_addr, 32'h0);
        chk("reset.ids", {bus_proc_id, wb_proc_id, bus_rdwr}, 5'b0);
        reset = 1'b1;
        tick();
        chk("idle.no_req", outv(), 14'b0);

        for (int v = 0; v < 8; v++) begin
            req_rdwr = tv[v].rdwr;
            for (int i = 0; i < NP; i++) req_addr[i*AW +: AW] = tv[v].base + 32'(i) * 32'h100;
            snoop_shared = tv[v].sh;
            snoop_wrbk = tv[v].wb;
            req = tv[v].req;
            run_txn($sformatf("vec%0d", v), tv[v].win, tv[v].exp_addr, tv[v].exp_sh,
                    tv[v].exp_wb, tv[v].exp_wb_id, tv[v].exp_rd, 1'b0);
            req = '0;
        end

        // Full contention straight out of reset: 0,1,2,3.
        snoop_shared = '0;
        snoop_wrbk = '0;
        req_rdwr = 4'b1111;
        for (int i = 0; i < NP; i++) req_addr[i*AW +: AW] = 32'h8000_0000 + 32'(i);
        reset = 1'b0;
        req = 4'b1111;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_txn($sformatf("rr_a%0d", k), order_a[k], 32'h8000_0000 + 32'(order_a[k]),
                    1'b0, 1'b0, 0, 1'b1, 1'b0);
        end
        tick();
        chk("rr_a.stays_idle", outv(), 14'b0);

        // Core 1 owns last, then everyone requests: 2,3,0,1.
        req = 4'b0010;
        run_txn("rr_pre", 1, 32'h8000_0001, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            run_txn($sformatf("rr_b%0d", k), order_b[k], 32'h8000_0000 + 32'(order_b[k]),
                    1'b0, 1'b0, 0, 1'b1, 1'b0);
        end

        // Reset during the second MEM cycle abandons core 0's read.
        req_rdwr = 4'b0011;
        req_addr[0 +: AW] = 32'h7777_0000;
        req_addr[AW +: AW] = 32'h2222_0010;
        req = 4'b0001;
        tick();
        chk("rst_mid.grant", gnt, 4'b0001);
        tick();
        tick();
        tick();
        chk("rst_mid.mem2", outv(), ev(4'b0001, 0, 0, 0, 1, 0, 4'b0, 1));
        reset = 1'b0;
        req = 4'b0010;
        tick();
        chk("rst_mid.cleared", outv(), 14'b0);
        chk("rst_mid.addr_cleared", bus_addr, 32'h0);
        reset = 1'b1;
        run_txn("rst_after", 1, 32'h2222_0010, 1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Owner drops req and changes its fields mid-transaction; nothing changes on the bus.
        req_rdwr = 4'b0010;
        req_addr[AW +: AW] = 32'h3333_0004;
        req = 4'b0010;
        run_txn("noise", 1, 32'h3333_0004, 1'b0, 1'b0, 0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
